// File: rtl/band_seq_pkg.sv
// Shared types and defaults for the band sequencer: FSM states, band codes,
// default watchdog length and the band-advance helper.
package band_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_LATCH,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    BAND_NONE = 2'b00,
    BAND_LOW  = 2'b01,
    BAND_MID  = 2'b10,
    BAND_HIGH = 2'b11
  } band_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

  // Saturates at HIGH so the band code can never wrap back to NONE.
  function automatic band_t next_band(input band_t b);
    case (b)
      BAND_LOW: return BAND_MID;
      BAND_MID: return BAND_HIGH;
      default:  return BAND_HIGH;
    endcase
  endfunction

endpackage

// File: rtl/band_sequencer_if.sv
// Control/status bundle between the band sequencer and its environment
// (sample source, shared filter, downstream band decode).
interface band_sequencer_if;
  logic       sample_tick;
  logic       filt_done;
  logic       clr_flags;
  logic [1:0] contador;
  logic       filt_start;
  logic       busy;
  logic       frame_done;
  logic       overrun;
  logic       timeout;

  modport master (
    output sample_tick, filt_done, clr_flags,
    input  contador, filt_start, busy, frame_done, overrun, timeout
  );

  modport slave (
    input  sample_tick, filt_done, clr_flags,
    output contador, filt_start, busy, frame_done, overrun, timeout
  );
endinterface

// File: rtl/band_seq_watchdog.sv
// WAIT-state watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT_CYCLES-th enabled cycle is reached.
module band_seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/band_sequencer.sv
// Steps a shared filter through the low/mid/high bands once per input sample.
// Optional WAIT watchdog is enabled by defining BAND_SEQ_TIMEOUT_EN.
module band_sequencer
  import band_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  band_sequencer_if.slave  bus
);

  state_t     state_q, state_n;
  band_t      band_q, band_n;
  logic [1:0] contador_q, contador_n;
  logic       filt_start_q, filt_start_n;
  logic       busy_q, busy_n;
  logic       frame_done_q, frame_done_n;
  logic       overrun_q, overrun_n;
  logic       timeout_q, timeout_n;
  logic       wd_expired;

`ifdef BAND_SEQ_TIMEOUT_EN
  band_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != ST_WAIT),
    .enable (state_q == ST_WAIT),
    .expired(wd_expired)
  );
`else
  // Parameter stays in the signature so both builds instantiate identically.
  assign wd_expired = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_n   = state_q;
    band_n    = band_q;
    overrun_n = overrun_q & ~bus.clr_flags;
    timeout_n = timeout_q & ~bus.clr_flags;

    case (state_q)
      ST_IDLE: begin
        band_n = BAND_LOW;
        if (bus.sample_tick) state_n = ST_START;
      end
      ST_START: state_n = ST_WAIT;
      ST_WAIT: begin
        if (bus.filt_done) begin
          state_n = ST_LATCH;
        end else if (wd_expired) begin
          state_n   = ST_IDLE;
          band_n    = BAND_LOW;
          timeout_n = 1'b1;
        end
      end
      ST_LATCH: begin
        if (band_q == BAND_HIGH) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_START;
          band_n  = next_band(band_q);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        band_n  = BAND_LOW;
      end
      default: begin
        state_n = ST_IDLE;
        band_n  = BAND_LOW;
      end
    endcase

    if (bus.sample_tick && (state_q != ST_IDLE)) overrun_n = 1'b1;

    // Outputs are decoded from the next state and registered with it.
    contador_n   = ((state_n == ST_IDLE) || (state_n == ST_DONE)) ? BAND_NONE : band_n;
    filt_start_n = (state_n == ST_START);
    busy_n       = (state_n != ST_IDLE);
    frame_done_n = (state_n == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      band_q       <= BAND_LOW;
      contador_q   <= BAND_NONE;
      filt_start_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_n;
      band_q       <= band_n;
      contador_q   <= contador_n;
      filt_start_q <= filt_start_n;
      busy_q       <= busy_n;
      frame_done_q <= frame_done_n;
      overrun_q    <= overrun_n;
      timeout_q    <= timeout_n;
    end
  end

  assign bus.contador   = contador_q;
  assign bus.filt_start = filt_start_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_band_sequencer.sv
// Directed bench for band_sequencer: filt_start/frame_done events are checked
// against a scoreboard queue filled as stimulus is driven.
module tb_band_sequencer;
  import band_seq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  band_sequencer_if bus ();

  band_sequencer #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  localparam logic [1:0] EV_START = 2'b10;
  localparam logic [1:0] EV_DONE  = 2'b01;

  typedef struct {
    logic [1:0] kind;
    logic [1:0] band;
    int         at;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [1:0] band, input int at);
    exp_q.push_back('{kind, band, at});
  endtask

  // Every filt_start / frame_done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.filt_start || bus.frame_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, bus.filt_start, bus.frame_done}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ev_kind", {30'd0, bus.filt_start, bus.frame_done}, {30'd0, mon_e.kind});
        check("ev_cycle", cyc, mon_e.at);
        check("ev_contador", {30'd0, bus.contador}, {30'd0, mon_e.band});
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_contador"}, {30'd0, bus.contador}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_filt_start"}, {31'd0, bus.filt_start}, 32'd0);
    check({tag, "_frame_done"}, {31'd0, bus.frame_done}, 32'd0);
  endtask

  task automatic start_frame();
    bus.sample_tick = 1'b1;
    expect_ev(EV_START, BAND_LOW, cyc + 1);
    step();
    bus.sample_tick = 1'b0;
  endtask

  // Called in the filt_start cycle of band b. inj: 0 none, 1 filt_done in START,
  // 2 tick (with clr) in WAIT then clr, 3 reset in WAIT, 4 tick during DONE.
  task automatic band_pass(input band_t b, input bit last, input int inj);
    int s;
    s = cyc;
    check("start_contador", {30'd0, bus.contador}, {30'd0, b});
    check("start_busy", {31'd0, bus.busy}, 32'd1);
    if (inj == 1) bus.filt_done = 1'b1;
    step();
    bus.filt_done = 1'b0;
    if (inj == 2) begin
      bus.sample_tick = 1'b1;
      bus.clr_flags   = 1'b1;
    end
    step();
    bus.sample_tick = 1'b0;
    bus.clr_flags   = 1'b0;
    if (inj == 2) begin
      check("overrun_set_wins", {31'd0, bus.overrun}, 32'd1);
      bus.clr_flags = 1'b1;
    end
    step();
    bus.clr_flags = 1'b0;
    if (inj == 2) check("overrun_cleared", {31'd0, bus.overrun}, 32'd0);
    if (inj == 3) begin
      reset = 1'b1;
      #1;
      check_idle("async_reset");
      check("async_reset_overrun", {31'd0, bus.overrun}, 32'd0);
      check("async_reset_timeout", {31'd0, bus.timeout}, 32'd0);
      return;
    end
    step();
    check("wait_contador", {30'd0, bus.contador}, {30'd0, b});
    check("wait_busy", {31'd0, bus.busy}, 32'd1);
    check("wait_overrun", {31'd0, bus.overrun}, 32'd0);
    step();
    bus.filt_done = 1'b1;
    if (last) expect_ev(EV_DONE, BAND_NONE, s + 7);
    else expect_ev(EV_START, next_band(b), s + 7);
    step();
    bus.filt_done = 1'b0;
    check("latch_contador", {30'd0, bus.contador}, {30'd0, b});
    check("latch_filt_start", {31'd0, bus.filt_start}, 32'd0);
    step();
    if (last) begin
      check("done_frame_done", {31'd0, bus.frame_done}, 32'd1);
      if (inj == 4) bus.sample_tick = 1'b1;
      step();
      bus.sample_tick = 1'b0;
      check_idle("post_done");
      check("post_done_overrun", {31'd0, bus.overrun}, (inj == 4) ? 32'd1 : 32'd0);
      if (inj == 4) begin
        bus.clr_flags = 1'b1;
        step();
        bus.clr_flags = 1'b0;
        check("overrun_clr_after_done", {31'd0, bus.overrun}, 32'd0);
        check_idle("no_restart_after_done");
      end
    end
  endtask

  initial begin
    bus.sample_tick = 1'b0;
    bus.filt_done   = 1'b0;
    bus.clr_flags   = 1'b0;

    @(posedge clk);
    @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_overrun", {31'd0, bus.overrun}, 32'd0);
    check("reset_timeout", {31'd0, bus.timeout}, 32'd0);

    // Nominal frame: tick at cycle 5, filt_done five cycles after each filt_start.
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    repeat (5) step();
    start_frame();
    band_pass(BAND_LOW, 1'b0, 0);
    band_pass(BAND_MID, 1'b0, 0);
    band_pass(BAND_HIGH, 1'b1, 0);

    // filt_done in IDLE and in START is ignored; overrun in WAIT; tick in DONE.
    bus.filt_done = 1'b1;
    step();
    bus.filt_done = 1'b0;
    check_idle("filt_done_idle");
    check("filt_done_idle_overrun", {31'd0, bus.overrun}, 32'd0);
    step();
    start_frame();
    band_pass(BAND_LOW, 1'b0, 1);
    band_pass(BAND_MID, 1'b0, 2);
    band_pass(BAND_HIGH, 1'b1, 4);

    // Reset mid-frame, then a tick in the same cycle reset releases.
    step();
    start_frame();
    band_pass(BAND_LOW, 1'b0, 0);
    band_pass(BAND_MID, 1'b0, 0);
    band_pass(BAND_HIGH, 1'b1, 3);
    step();
    step();
    reset = 1'b0;
    start_frame();
    band_pass(BAND_LOW, 1'b0, 0);
    band_pass(BAND_MID, 1'b0, 0);
    band_pass(BAND_HIGH, 1'b1, 0);

`ifdef BAND_SEQ_TIMEOUT_EN
    step();
    start_frame();
    repeat (8) step();
    check("wd_still_busy", {31'd0, bus.busy}, 32'd1);
    step();
    check("wd_timeout", {31'd0, bus.timeout}, 32'd1);
    check_idle("wd_abort");
    bus.clr_flags = 1'b1;
    step();
    bus.clr_flags = 1'b0;
    check("wd_timeout_clr", {31'd0, bus.timeout}, 32'd0);
`else
    check("timeout_tied", {31'd0, bus.timeout}, 32'd0);
`endif

    repeat (3) step();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
